id_ex_alu_issue: RTL and testbench
==================================

ID_EX_ALU_ISSUE -- requirements
Module: id_ex_alu_issue

Interface
REQ-001 SHALL have clock and reset as follows: one clock; reset is asynchronous and active-low.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  in  1  decode slot holds an instruction.
REQ-005 SHALL have ports: in_ready  out  1  block accepts the instruction this cycle.
REQ-006 SHALL have ports: instr  in  32  MIPS instruction word.
REQ-007 SHALL have ports: rs_data, rt_data  in  32 each  register-file read values.
REQ-008 SHALL have ports: flush  in  1  discard the held entry and the incoming instruction.
REQ-009 SHALL have ports: out_valid  out  1  the EX stage holds a valid entry.
REQ-010 SHALL have ports: out_ready  in  1  the EX stage consumes the entry this cycle.
REQ-011 SHALL have ports: alu_op  out  3  ALU opcode: 000 and, 001 or, 010 add, 011 lui, 110 sub, 111 slt.
REQ-012 SHALL have ports: op_a, op_b  out  32 each  ALU operands.
REQ-013 SHALL have ports: dest  out  5  writeback register; reg_write  out  1; mem_rd, mem_wr  out  1 each; illegal  out  1.

Function
REQ-014 SHALL decode R-type (opcode 0) funct values as follows: 0x24 gives and; 0x25 gives or; 0x20 and 0x21 give add; 0x22 and 0x23 give sub; 0x2A gives slt. For these, op_b=rt_data, dest=rd, reg_write=1.
REQ-015 SHALL decode I-type opcodes as follows: 0x08 and 0x09 give add with a sign-extended immediate; 0x0A gives slt with a sign-extended immediate; 0x0C gives and with a zero-extended immediate; 0x0D gives or with a zero-extended immediate; 0x0F gives lui with op_b={16'b0,imm}. For all of these, dest=rt and reg_write=1.
REQ-016 SHALL decode 0x23 (lw) as add with a sign-extended immediate, dest=rt, reg_write=1, mem_rd=1.
REQ-017 SHALL decode 0x2B (sw) as add with a sign-extended immediate, reg_write=0, mem_wr=1, and SHALL forward rt_data on op_b only through the ALU path (store data is out of scope).
REQ-018 SHALL drive op_a=rs_data for every instruction.
REQ-019 SHALL treat any other encoding as illegal: illegal=1, alu_op=010, reg_write=0, mem_rd=0, mem_wr=0, dest=0.
REQ-020 SHALL force reg_write=0 whenever dest is 0.
REQ-021 SHALL register all outputs, with a latency of 1 cycle from the accept edge to out_valid.
REQ-022 SHALL define accept as in_valid&&in_ready&&!flush.
REQ-023 SHALL define a transfer out as out_valid&&out_ready.
REQ-024 SHALL hold all outputs stable while out_valid&&!out_ready.
REQ-025 SHALL allow a simultaneous transfer out and accept in one cycle, at full throughput.
REQ-026 SHALL, when flush is asserted, clear out_valid on the next edge, ignore in_valid, and take priority over the other conditions.
REQ-027 SHALL drive in_ready=!out_valid||out_ready when the skid buffer is absent.

Reset
REQ-028 SHALL, while rst_n is low, force out_valid=0, alu_op=000, op_a=0, op_b=0, dest=0, reg_write=0, mem_rd=0, mem_wr=0 and illegal=0.
REQ-029 SHALL, when reset asserts mid-stall, drop the held entry and SHALL NOT present it after reset.
REQ-030 SHALL drive in_ready=0 during reset and SHALL drive in_ready=1 in the first cycle after rst_n rises.

Configuration
REQ-031 SHALL use the macro ISSUE_SKID_EN to control the skid buffer.
REQ-032 SHALL, when ISSUE_SKID_EN is defined, add a one-entry skid buffer so that in_ready is registered and equal to "skid empty", with no combinational path from out_ready.
REQ-033 SHALL, when ISSUE_SKID_EN is defined, capture an accepted instruction that arrives during a stall into the skid, promote it on the next transfer out, and clear both skid and main entry on flush.
REQ-034 SHALL, when ISSUE_SKID_EN is undefined, implement REQ-027 with no skid storage.
REQ-035 SHALL keep ordering and the latency defined in REQ-021 identical when the skid is empty, with or without ISSUE_SKID_EN.

Structure
REQ-036 SHALL place the ALU opcode localparams (AND, OR, ADD, LUI, SUB, SLT), the MIPS opcode and funct constants, and a packed decoded-entry struct (alu_op, op_a, op_b, dest, reg_write, mem_rd, mem_wr, illegal) in a shared package, mips_pkg.
REQ-037 SHALL implement decode in a combinational sub-module, alu_decode (instr, rs_data, rt_data to entry), with the registers, handshake and skid in id_ex_alu_issue.

Verification
REQ-038 SHALL cover: reset, then instr=0x012A4020 (add $8,$9,$10), rs_data=5, rt_data=7 -> next cycle out_valid=1, alu_op=010, op_a=5, op_b=7, dest=8, reg_write=1.
REQ-039 SHALL cover: instr=0x3C081234 (lui) -> alu_op=011, op_b=0x00001234, dest=8; instr=0x2108FFFF (addi -1) -> op_b=0xFFFFFFFF.
REQ-040 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> outputs held; no skid: in_ready=0; ISSUE_SKID_EN: one extra accepted, then in_ready=0, and both entries emerge in order.
REQ-041 SHALL cover: flush asserted with a valid entry held and in_valid=1 -> out_valid=0 next cycle, and neither instruction is ever presented.
REQ-042 SHALL cover: instr=0xFC000000 -> illegal=1, reg_write=0, alu_op=010; instr=0x00004020 with dest=0 variant 0x00000020 -> reg_write=0.
REQ-043 SHALL cover: rst_n dropped asynchronously mid-stall -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the decoded ID/EX entry.
// ALU opcodes follow the EX stage ALU encoding.
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef struct packed {
        logic [2:0]  alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode of one instruction into an ID/EX entry.
// Unsupported encodings decode as an illegal add with no side effects.
module alu_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output entry_t      ent
);

    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        legal;
    logic        wr;
    logic [4:0]  dst;

    assign opc  = instr[31:26];
    assign fn   = instr[5:0];
    assign sext = {{16{instr[15]}}, instr[15:0]};
    assign zext = {16'h0000, instr[15:0]};

    always_comb begin
        ent        = '0;
        ent.op_a   = rs_data;
        ent.op_b   = rt_data;
        ent.alu_op = ALU_ADD;
        legal      = 1'b1;
        wr         = 1'b0;
        dst        = 5'd0;
        unique case (1'b1)
            opc == OP_RTYPE: begin
                dst = instr[15:11];
                wr  = 1'b1;
                unique case (1'b1)
                    fn == F_AND: ent.alu_op = ALU_AND;
                    fn == F_OR:  ent.alu_op = ALU_OR;
                    fn == F_ADD || fn == F_ADDU:
                        ent.alu_op = ALU_ADD;
                    fn == F_SUB || fn == F_SUBU:
                        ent.alu_op = ALU_SUB;
                    fn == F_SLT: ent.alu_op = ALU_SLT;
                    default:     legal = 1'b0;
                endcase
            end
            opc == OP_ADDI || opc == OP_ADDIU: begin
                ent.op_b = sext;
                dst      = instr[20:16];
                wr       = 1'b1;
            end
            opc == OP_SLTI: begin
                ent.alu_op = ALU_SLT;
                ent.op_b   = sext;
                dst        = instr[20:16];
                wr         = 1'b1;
            end
            opc == OP_ANDI: begin
                ent.alu_op = ALU_AND;
                ent.op_b   = zext;
                dst        = instr[20:16];
                wr         = 1'b1;
            end
            opc == OP_ORI: begin
                ent.alu_op = ALU_OR;
                ent.op_b   = zext;
                dst        = instr[20:16];
                wr         = 1'b1;
            end
            opc == OP_LUI: begin
                ent.alu_op = ALU_LUI;
                ent.op_b   = zext;
                dst        = instr[20:16];
                wr         = 1'b1;
            end
            opc == OP_LW: begin
                ent.op_b   = sext;
                ent.mem_rd = 1'b1;
                dst        = instr[20:16];
                wr         = 1'b1;
            end
            opc == OP_SW: begin
                ent.op_b   = sext;
                ent.mem_wr = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            ent.alu_op = ALU_ADD;
            ent.mem_rd = 1'b0;
            ent.mem_wr = 1'b0;
            dst        = 5'd0;
            wr         = 1'b0;
        end
        ent.illegal   = !legal;
        ent.dest      = dst;
        // $0 is hardwired, so a write to it is dropped here
        ent.reg_write = wr && (dst != 5'd0);
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue register with valid/ready handshake and flush.
// ISSUE_SKID_EN adds a one-entry skid so in_ready is registered.
module id_ex_alu_issue
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  alu_op,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        illegal
);

    entry_t dec;
    entry_t ent;
    logic   vld;
    logic   acc;
    logic   xfer;

    alu_decode u_dec (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .ent     (dec)
    );

    assign acc       = in_valid && in_ready && !flush;
    assign xfer      = vld && out_ready;
    assign out_valid = vld;
    assign alu_op    = ent.alu_op;
    assign op_a      = ent.op_a;
    assign op_b      = ent.op_b;
    assign dest      = ent.dest;
    assign reg_write = ent.reg_write;
    assign mem_rd    = ent.mem_rd;
    assign mem_wr    = ent.mem_wr;
    assign illegal   = ent.illegal;

`ifdef ISSUE_SKID_EN
    entry_t skid;
    logic   skid_vld;

    assign in_ready = rst_n && !skid_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld      <= 1'b0;
            ent      <= '0;
            skid_vld <= 1'b0;
            skid     <= '0;
        end else if (flush) begin
            vld      <= 1'b0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            if (xfer) begin
                ent      <= skid;
                skid_vld <= 1'b0;
            end
        end else if (acc) begin
            if (!vld || out_ready) begin
                ent <= dec;
                vld <= 1'b1;
            end else begin
                skid     <= dec;
                skid_vld <= 1'b1;
            end
        end else if (xfer) begin
            vld <= 1'b0;
        end
    end
`else
    assign in_ready = rst_n && (!vld || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            ent <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (acc) begin
            ent <= dec;
            vld <= 1'b1;
        end else if (xfer) begin
            vld <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue, with or without ISSUE_SKID_EN.
// Expected entries are queued on accept and compared on transfer out.
module tb_id_ex_alu_issue;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    entry_t sbq[$];
    entry_t held;
    logic   held_v = 1'b0;

    id_ex_alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .dest      (dest),
        .reg_write (reg_write),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic entry_t model(
        input logic [31:0] i,
        input logic [31:0] a,
        input logic [31:0] b
    );
        entry_t m;
        logic [31:0] se;
        logic [31:0] ze;
        se = {{16{i[15]}}, i[15:0]};
        ze = {16'h0000, i[15:0]};
        m = '0;
        m.op_a = a;
        m.op_b = b;
        m.alu_op = 3'b010;
        case (i[31:26])
            6'h00: begin
                m.dest = i[15:11];
                m.reg_write = 1'b1;
                case (i[5:0])
                    6'h24: m.alu_op = 3'b000;
                    6'h25: m.alu_op = 3'b001;
                    6'h20, 6'h21: m.alu_op = 3'b010;
                    6'h22, 6'h23: m.alu_op = 3'b110;
                    6'h2A: m.alu_op = 3'b111;
                    default: m.illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin
                m.op_b = se; m.dest = i[20:16]; m.reg_write = 1'b1;
            end
            6'h0A: begin
                m.alu_op = 3'b111; m.op_b = se;
                m.dest = i[20:16]; m.reg_write = 1'b1;
            end
            6'h0C: begin
                m.alu_op = 3'b000; m.op_b = ze;
                m.dest = i[20:16]; m.reg_write = 1'b1;
            end
            6'h0D: begin
                m.alu_op = 3'b001; m.op_b = ze;
                m.dest = i[20:16]; m.reg_write = 1'b1;
            end
            6'h0F: begin
                m.alu_op = 3'b011; m.op_b = ze;
                m.dest = i[20:16]; m.reg_write = 1'b1;
            end
            6'h23: begin
                m.op_b = se; m.dest = i[20:16];
                m.reg_write = 1'b1; m.mem_rd = 1'b1;
            end
            6'h2B: begin
                m.op_b = se; m.mem_wr = 1'b1;
            end
            default: m.illegal = 1'b1;
        endcase
        if (m.illegal) begin
            m.dest = 5'd0; m.reg_write = 1'b0;
            m.mem_rd = 1'b0; m.mem_wr = 1'b0;
        end
        if (m.dest == 5'd0) m.reg_write = 1'b0;
        return m;
    endfunction

    // Monitor: samples 2 time units after each falling edge
    always @(negedge clk) begin
        entry_t g;
        entry_t e;
        logic ok;
        #2;
        g = '{alu_op, op_a, op_b, dest, reg_write,
              mem_rd, mem_wr, illegal};
        if (!rst_n) begin
            sbq.delete();
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                checks++;
                if (g !== held) begin
                    errors++;
                    $display("FAIL hold_stable got %h want %h", g, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got %h want none", g);
                end else begin
                    e = sbq.pop_front();
                    ok = g.alu_op === e.alu_op && g.op_a === e.op_a &&
                         (e.illegal || g.op_b === e.op_b) &&
                         (e.mem_wr || g.dest === e.dest) &&
                         g.reg_write === e.reg_write &&
                         g.mem_rd === e.mem_rd &&
                         g.mem_wr === e.mem_wr &&
                         g.illegal === e.illegal;
                    if (!ok) begin
                        errors++;
                        $display("FAIL scoreboard got %h want %h", g, e);
                    end
                end
            end
            if (flush) sbq.delete();
            else if (in_valid && in_ready)
                sbq.push_back(model(instr, rs_data, rt_data));
            held_v = out_valid && !out_ready;
            held = g;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [31:0] i,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        instr = i;
        rs_data = a;
        rt_data = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_reset;
        out_ready = 1'b1;
        drive(1'b1, 32'h012A4020, 32'd1, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, alu_op, op_a, op_b, dest,
             reg_write, mem_rd, mem_wr, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b r=%b op=%b a=%h b=%h",
                     out_valid, in_ready, alu_op, op_a, op_b);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", in_ready);
        end
    endtask

    task automatic test_add;
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 32'h012A4020, 32'd5, 32'd7);
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alu_op, op_a, op_b, dest, reg_write} !==
            {1'b1, 3'b010, 32'd5, 32'd7, 5'd8, 1'b1}) begin
            errors++;
            $display("FAIL add got v=%b op=%b a=%h b=%h d=%0d w=%b",
                     out_valid, alu_op, op_a, op_b, dest, reg_write);
        end
        idle(2);
    endtask

    task automatic test_lui_addi;
        @(negedge clk);
        drive(1'b1, 32'h3C081234, 32'h55, 32'h66);
        @(posedge clk);
        #1;
        checks++;
        if ({alu_op, op_b, dest} !== {3'b011, 32'h00001234, 5'd8}) begin
            errors++;
            $display("FAIL lui got op=%b b=%h d=%0d want 011 1234 8",
                     alu_op, op_b, dest);
        end
        @(negedge clk);
        drive(1'b1, 32'h2108FFFF, 32'h10, 32'h20);
        @(posedge clk);
        #1;
        checks++;
        if ({alu_op, op_b} !== {3'b010, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL addi_neg got op=%b b=%h want 010 ffffffff",
                     alu_op, op_b);
        end
        idle(2);
    endtask

    task automatic test_decode_table;
        logic [31:0] tbl [14];
        tbl = '{32'h00221824, 32'h00221825, 32'h00221821,
                32'h00221822, 32'h00221823, 32'h0022182A,
                32'h2825FFFD, 32'h3025F00F, 32'h3425F00F,
                32'h24258000, 32'h8C25FFFC, 32'hAC250010,
                32'h00221800, 32'h10220004};
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(1'b1, tbl[k], $urandom, $urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL throughput_ready got %b want 1", in_ready);
            end
        end
        @(negedge clk);
        drive(1'b1, 32'h20200005, 32'h3, 32'h4);
        @(posedge clk);
        #1;
        checks++;
        if (reg_write !== 1'b0) begin
            errors++;
            $display("FAIL addi_r0 got w=%b want 0", reg_write);
        end
        idle(3);
    endtask

    task automatic test_stall;
        logic [31:0] seq [4];
        int k;
        int acc;
        int want;
        seq = '{32'h00221824, 32'h00432025, 32'h00642822, 32'h0085302A};
        k = 0;
        acc = 0;
`ifdef ISSUE_SKID_EN
        want = 1;
`else
        want = 0;
`endif
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, seq[0], 32'hA, 32'hB);
        k = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, seq[k], 32'h100 + k, 32'h200 + k);
            #1;
            if (in_ready) begin
                acc++;
                k++;
            end
        end
        checks++;
        if (acc !== want || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept got %0d r=%b want %0d r=0",
                     acc, in_ready, want);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        out_ready = 1'b1;
        idle(4);
        checks++;
        if (sbq.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain got q=%0d v=%b want 0 0",
                     sbq.size(), out_valid);
        end
    endtask

    task automatic test_flush;
        int seen;
        seen = 0;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h00221824, 32'h1, 32'h2);
        @(negedge clk);
        drive(1'b1, 32'h00221825, 32'h3, 32'h4);
        @(negedge clk);
        drive(1'b1, 32'h00221822, 32'h5, 32'h6);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got %b want 0", out_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_ghost got %0d want 0", seen);
        end
    endtask

    task automatic test_illegal_dest0;
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 32'hFC000000, 32'h9, 32'h9);
        @(posedge clk);
        #1;
        checks++;
        if ({illegal, reg_write, alu_op} !== {1'b1, 1'b0, 3'b010}) begin
            errors++;
            $display("FAIL illegal got i=%b w=%b op=%b want 1 0 010",
                     illegal, reg_write, alu_op);
        end
        @(negedge clk);
        drive(1'b1, 32'h00004020, 32'h1, 32'h1);
        @(posedge clk);
        #1;
        checks++;
        if ({reg_write, dest} !== {1'b1, 5'd8}) begin
            errors++;
            $display("FAIL add_rd8 got w=%b d=%0d want 1 8",
                     reg_write, dest);
        end
        @(negedge clk);
        drive(1'b1, 32'h00000020, 32'h1, 32'h1);
        @(posedge clk);
        #1;
        checks++;
        if ({reg_write, dest} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL add_rd0 got w=%b d=%0d want 0 0",
                     reg_write, dest);
        end
        idle(2);
    endtask

    task automatic test_async_reset;
        int seen;
        seen = 0;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h012A4020, 32'h77, 32'h88);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset got v=%b r=%b want 0 0",
                     out_valid, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_ghost got %0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lui_addi();
        test_decode_table();
        test_stall();
        test_flush();
        test_illegal_dest0();
        test_async_reset();
        idle(2);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_empty got %0d want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
